// File: rtl/and_gate_pkg.sv
// and_gate_pkg: shared constants for the switch-to-LED block
package and_gate_pkg;
  localparam int DEBOUNCE_LIMIT_DEFAULT = 250000;
  localparam logic LED_RESET_XNOR = 1'b1;
  localparam logic LED_RESET_TOGGLE = 1'b0;
endpackage

// File: rtl/and_gate_project_debounce_filter.sv
// debounce_filter: 2-flop synchronizer followed by a stable-for-N-cycles filter
module debounce_filter
  import and_gate_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Raw,
  output logic o_Stable
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  logic meta, sync;
  logic [CW-1:0] count;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      o_Stable <= 1'b0;
      count <= '0;
    end else begin
      meta <= i_Raw;
      sync <= meta;
      if (sync == o_Stable) count <= '0;
      else if (count == LAST) begin
        o_Stable <= sync;
        count <= '0;
      end else count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/and_gate_project.sv
// and_gate_project: switch XNOR to LEDs, raw, debounced and toggle indicator
module and_gate_project
  import and_gate_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_LED_1,
  output logic o_LED_2,
  output logic o_LED_3
);
  logic stable_1, stable_2, xnor_db;
  assign o_LED_1 = ~(i_Switch_1 ^ i_Switch_2);
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_1 (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Raw(i_Switch_1), .o_Stable(stable_1)
  );
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_db_2 (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Raw(i_Switch_2), .o_Stable(stable_2)
  );
  assign xnor_db = ~(stable_1 ^ stable_2);
  // o_LED_2 is exactly the previous xnor_db, so it doubles as the rise detector
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_LED_2 <= LED_RESET_XNOR;
      o_LED_3 <= LED_RESET_TOGGLE;
    end else begin
      o_LED_2 <= xnor_db;
      o_LED_3 <= o_LED_3 ^ (xnor_db & ~o_LED_2);
    end
  end
endmodule

// File: tb/tb_and_gate_project.sv
// tb_and_gate_project: directed plan plus randomized scoreboard against a reference model
module tb_and_gate_project;
  localparam int L = 4;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0, sw1 = 1'b0, sw2 = 1'b0;
  logic led1, led2, led3;
  int pass_cnt = 0, tot_cnt = 0;

  and_gate_project #(.DEBOUNCE_LIMIT(L)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_LED_1(led1), .o_LED_2(led2), .o_LED_3(led3)
  );

  initial forever #5 clk = clk_en ? ~clk : 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: a switch value is accepted once its synchronized copy has
  // disagreed with the accepted state for L consecutive clocks.
  bit armed = 0;
  bit rh1[2], rh2[2];
  bit st1, st2, e2, e3, x_m;
  bit w1[$], w2[$];
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;

  function automatic bit full_mismatch(input bit w[$], input bit st);
    if (w.size() != L) return 1'b0;
    foreach (w[i]) if (w[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1;
      rh1 = '{0, 0};
      rh2 = '{0, 0};
      w1.delete();
      w2.delete();
      st1 = 0;
      st2 = 0;
      e2 = 1;
      e3 = 0;
    end else if (armed) begin
      x_m = (st1 == st2);
      e3 = e3 ^ (x_m & ~e2);
      e2 = x_m;
      w1.push_back(rh1[1]);
      w2.push_back(rh2[1]);
      if (w1.size() > L) void'(w1.pop_front());
      if (w2.size() > L) void'(w2.pop_front());
      rh1[1] = rh1[0];
      rh1[0] = sw1;
      rh2[1] = rh2[0];
      rh2[0] = sw2;
      if (full_mismatch(w1, st1)) begin
        st1 = !st1;
        w1.delete();
      end
      if (full_mismatch(w2, st2)) begin
        st2 = !st2;
        w2.delete();
      end
    end
    if (armed) exp_q.push_back({e2, e3});
  end

  always @(negedge clk) begin
    chk("led1_comb", led1, sw1 == sw2);
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      chk("led2_model", led2, mon_exp[1]);
      chk("led3_model", led3, mon_exp[0]);
    end
  end

  logic [1:0] pat[4] = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic exp_tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int i = 0; i < 4; i++) begin
      {sw1, sw2} = pat[i];
      #10;
      chk("truth_table", led1, exp_tt[i]);
    end
    clk_en = 1'b1;
    rst = 1'b1;
    {sw1, sw2} = 2'b11;
    repeat (3) tick();
    chk("reset_led2", led2, 1'b1);
    chk("reset_led3", led3, 1'b0);
    chk("reset_led1", led1, 1'b1);
    {sw1, sw2} = 2'b00;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    sw1 = 1'b1;
    #1 chk("latency_led1", led1, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk("latency_led2", led2, e < 7);
    end
    sw2 = 1'b1;
    #1 chk("glitch_led1", led1, 1'b1);
    tick();
    tick();
    sw2 = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk("glitch_led2", led2, 1'b0);
      chk("glitch_led3", led3, 1'b0);
    end
    sw2 = 1'b1;
    repeat (10) tick();
    chk("toggle1_led2", led2, 1'b1);
    chk("toggle1_led3", led3, 1'b1);
    sw2 = 1'b0;
    repeat (10) tick();
    chk("toggle2_led2", led2, 1'b0);
    chk("toggle2_led3", led3, 1'b1);
    sw2 = 1'b1;
    repeat (10) tick();
    chk("toggle3_led2", led2, 1'b1);
    chk("toggle3_led3", led3, 1'b0);
    {sw1, sw2} = 2'b00;
    repeat (10) tick();
    sw1 = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_led2", led2, 1'b1);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk("midreset_lat_led2", led2, e < 7);
    end
    repeat (80) begin
      {sw1, sw2} = 2'($urandom);
      repeat ($urandom_range(1, 10)) begin
        tick();
        rst = ($urandom_range(0, 49) == 0);
      end
    end
    rst = 1'b0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/and_gate_project.md
# and_gate_project

Switch-to-LED logic block for the board top level. Drives an LED combinationally with the XNOR of two slide switches (LED lit when the switches agree). Also provides a synchronized, debounced copy of the same function and a toggle indicator for board-level demonstration. Sits directly between the switch pins and the LED pins.

## Interface
- DEBOUNCE_LIMIT, 250000, consecutive stable clock cycles required to accept a switch change; legal range ≥ 1; 10 ms at 25 MHz.
- i_Clk  input  1  system clock, all registers on rising edge.
- i_Reset  input  1  reset, synchronous, active-high.
- i_Switch_1  input  1  raw switch 1, asynchronous to i_Clk.
- i_Switch_2  input  1  raw switch 2, asynchronous to i_Clk.
- o_LED_1  output  1  combinational: ~(i_Switch_1 ^ i_Switch_2).
- o_LED_2  output  1  registered: XNOR of the debounced switch states.
- o_LED_3  output  1  registered: toggles on each rising edge of the debounced XNOR.

## Operation
- o_LED_1 truth table: 00→1, 10→0, 01→0, 11→1.
- o_LED_1 is purely combinational, with no register in its path. It is independent of i_Clk and i_Reset, including while reset is asserted or the clock is stopped.
- Each switch passes through a 2-flop synchronizer, then a debounce filter.
- Debounce filter per switch:
  - Holds a stable state and a counter of width clog2(DEBOUNCE_LIMIT)+1.
  - While the synchronized input ≠ stable, the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_LIMIT-1 with mismatch still present, stable takes the input and the counter clears.
  - Any cycle with input == stable clears the counter, which rejects the glitch.
- xnor_db = ~(stable_1 ^ stable_2). o_LED_2 registers xnor_db.
- o_LED_3 inverts on a cycle where xnor_db = 1 and its previous registered value = 0.
- Simultaneous change of both switches: the filters are independent. o_LED_2 may show one intermediate value for a cycle if the filters accept on different cycles. That intermediate value is permitted.

## Timing
- Reset (i_Reset=1 at a rising edge) sets all of the following:
  - synchronizer flops = 0
  - stable states = 0
  - counters = 0
  - o_LED_2 = 1
  - xnor_db previous = 1
  - o_LED_3 = 0
- o_LED_1 is unaffected by reset.
- Reset mid-count discards the count. The filter restarts from stable = 0 after reset deasserts.
- o_LED_1 latency is zero, combinational only.
- o_LED_2 latency, for a clean switch change sampled at edge 0:
  - synchronizer output changes after edge 2
  - stable changes at edge 2+DEBOUNCE_LIMIT
  - o_LED_2 changes at edge 3+DEBOUNCE_LIMIT
- o_LED_3 changes on the same edge o_LED_2 rises from 0 to 1.
- DEBOUNCE_LIMIT=1: a single mismatching cycle is accepted.

## Structure
- Shared package and_gate_pkg:
  - DEBOUNCE_LIMIT_DEFAULT = 250000
  - LED_RESET_XNOR = 1'b1
  - LED_RESET_TOGGLE = 1'b0
- One sub-module, debounce_filter:
  - parameter DEBOUNCE_LIMIT
  - ports i_Clk, i_Reset, i_Raw, o_Stable
  - contains the synchronizer and counter
  - instantiated twice
- Top level holds the combinational XNOR, the o_LED_2 register, and the toggle logic.

## Test plan
- Combinational truth table, no clock running: apply 00, 10, 01, 11, holding each 10 time units. Required o_LED_1 = 1, 0, 0, 1 respectively.
- Reset values: hold i_Reset=1 for 3 edges with switches 11. Required o_LED_2=1, o_LED_3=0, o_LED_1=1.
- Debounce latency, DEBOUNCE_LIMIT=4, from reset with switches 00: set i_Switch_1=1 before edge 0. Required o_LED_2 falls at edge 7 and stays 0; o_LED_1 falls immediately.
- Glitch rejection, DEBOUNCE_LIMIT=4: pulse i_Switch_2 high for 2 cycles. Required o_LED_2 and o_LED_3 unchanged throughout; o_LED_1 follows the pulse.
- Toggle: DEBOUNCE_LIMIT=4, switches 10 settled (o_LED_2=0). Set 11 (o_LED_2→1, o_LED_3 0→1), then 10, then 11. Required o_LED_3 = 0 after the second rise.
- Reset mid-count: DEBOUNCE_LIMIT=4. Change i_Switch_1 to 1, assert reset 2 edges after the synchronizer output changes, then release. Required stable restarts at 0, and acceptance takes a full 3+DEBOUNCE_LIMIT edges after release.
